digit_entry: RTL and testbench

User-input front end for the UART board: debounces three push-buttons, lets the operator pick the baud-rate select and compose one data byte hex-nibble by hex-nibble, and issues a transmit request with a busy handshake. It drives `mode`/`msg` straight into `DigitsDisplay`, so the 7-segment digits always show what is being edited, and drives `baud_sel`, `tx_data` and `tx_start` into the clock-select and TX path.

---
 rtl/digit_entry_pkg.sv | 42 ++++
 rtl/digit_entry_debounce.sv | 45 ++++
 rtl/digit_entry.sv | 101 ++++++++++
 tb/tb_digit_entry.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/digit_entry_pkg.sv
// Shared encodings for the digit entry front end: baud selects, display modes and FSM states.
`ifndef DIGIT_ENTRY_COMMON
`define DIGIT_ENTRY_COMMON
`define SEL_9600      2'd0
`define SEL_57600     2'd1
`define SEL_115200    2'd2
`define BAUDRATE_MODE 1'b0
`define DATA_MODE     1'b1
`define ENTRY_BAUD    2'd0
`define ENTRY_LO      2'd1
`define ENTRY_HI      2'd2
`define ENTRY_SEND    2'd3
`endif

package digit_entry_pkg;

  localparam int unsigned MSG_W = 8;
  localparam int unsigned SEL_W = 2;

  localparam logic [SEL_W-1:0] SEL_9600      = `SEL_9600;
  localparam logic [SEL_W-1:0] SEL_57600     = `SEL_57600;
  localparam logic [SEL_W-1:0] SEL_115200    = `SEL_115200;
  localparam logic             BAUDRATE_MODE = `BAUDRATE_MODE;
  localparam logic             DATA_MODE     = `DATA_MODE;

  typedef enum logic [1:0] {
    ST_BAUD = `ENTRY_BAUD,
    ST_LO   = `ENTRY_LO,
    ST_HI   = `ENTRY_HI,
    ST_SEND = `ENTRY_SEND
  } entry_state_e;

  // Baud select rotation 9600 -> 57600 -> 115200 -> 9600.
  function automatic logic [SEL_W-1:0] next_baud(input logic [SEL_W-1:0] sel);
    case (sel)
      SEL_9600:  next_baud = SEL_57600;
      SEL_57600: next_baud = SEL_115200;
      default:   next_baud = SEL_9600;
    endcase
  endfunction

endpackage

// File: rtl/digit_entry_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter and rising-edge pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic src_clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic             stable;
  logic             stable_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge src_clk) begin
    if (rst) begin
      sync_q1  <= 1'b0;
      sync_q2  <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= '0;
      pulse    <= 1'b0;
    end else begin
      sync_q1  <= raw;
      sync_q2  <= sync_q1;
      stable_d <= stable;
      pulse    <= stable & ~stable_d;
      // The level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
      if (sync_q2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= ~stable;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/digit_entry.sv
// Operator front end: baud select and hex byte composition from three buttons, with a TX request handshake.
module digit_entry
  import digit_entry_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic             src_clk,
  input  logic             rst,
  input  logic             btn_next,
  input  logic             btn_inc,
  input  logic             btn_send,
  input  logic             tx_busy,
  output logic             mode,
  output logic [MSG_W-1:0] msg,
  output logic [SEL_W-1:0] baud_sel,
  output logic [MSG_W-1:0] tx_data,
  output logic             tx_start
);

  logic             next_p;
  logic             inc_p;
  logic             send_p;
  entry_state_e     state;
  logic [MSG_W-1:0] data_reg;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .src_clk(src_clk), .rst(rst), .raw(btn_next), .pulse(next_p)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .src_clk(src_clk), .rst(rst), .raw(btn_inc), .pulse(inc_p)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_send (
    .src_clk(src_clk), .rst(rst), .raw(btn_send), .pulse(send_p)
  );

  // Edit FSM; mode/msg are updated alongside every state or field change so the display never lags.
  always_ff @(posedge src_clk) begin
    if (rst) begin
      state    <= ST_BAUD;
      data_reg <= '0;
      baud_sel <= SEL_9600;
      mode     <= BAUDRATE_MODE;
      msg      <= {6'b0, SEL_9600};
      tx_data  <= '0;
      tx_start <= 1'b0;
    end else begin
      case (state)
        ST_BAUD: begin
          if (send_p) begin
            // send has top priority even where it does nothing
          end else if (next_p) begin
            state <= ST_LO;
            mode  <= DATA_MODE;
            msg   <= data_reg;
          end else if (inc_p) begin
            baud_sel <= next_baud(baud_sel);
            msg      <= {6'b0, next_baud(baud_sel)};
          end
        end
        ST_LO, ST_HI: begin
          if (send_p) begin
            if (!tx_busy) begin
              tx_data  <= data_reg;
              tx_start <= 1'b1;
              state    <= ST_SEND;
            end
          end else if (next_p) begin
            if (state == ST_LO) begin
              state <= ST_HI;
            end else begin
              state <= ST_BAUD;
              mode  <= BAUDRATE_MODE;
              msg   <= {6'b0, baud_sel};
            end
          end else if (inc_p) begin
            if (state == ST_LO) begin
              data_reg[3:0] <= data_reg[3:0] + 4'd1;
              msg           <= {data_reg[7:4], data_reg[3:0] + 4'd1};
            end else begin
              data_reg[7:4] <= data_reg[7:4] + 4'd1;
              msg           <= {data_reg[7:4] + 4'd1, data_reg[3:0]};
            end
          end
        end
        ST_SEND: begin
          if (tx_start) begin
            if (tx_busy) tx_start <= 1'b0;
          end else if (!tx_busy) begin
            state <= ST_LO;
          end
        end
        default: begin
          state <= ST_BAUD;
          mode  <= BAUDRATE_MODE;
          msg   <= {6'b0, baud_sel};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digit_entry.sv
// Randomized self-checking bench for digit_entry against a field-level model of the editor.
module tb_digit_entry;
  import digit_entry_pkg::*;

  logic       src_clk;
  logic       rst;
  logic       btn_next;
  logic       btn_inc;
  logic       btn_send;
  logic       tx_busy;
  logic       mode;
  logic [7:0] msg;
  logic [1:0] baud_sel;
  logic [7:0] tx_data;
  logic       tx_start;

  int checks;
  int failures;

  // Model: 0 = baud, 1 = low nibble, 2 = high nibble, 3 = sending
  int         m_st;
  int         m_baud;
  int         m_data;
  int         m_txd;
  logic [1:0] sel_tab [3];

  digit_entry #(.DEBOUNCE_CYCLES(4)) dut (
    .src_clk(src_clk), .rst(rst), .btn_next(btn_next), .btn_inc(btn_inc),
    .btn_send(btn_send), .tx_busy(tx_busy), .mode(mode), .msg(msg),
    .baud_sel(baud_sel), .tx_data(tx_data), .tx_start(tx_start)
  );

  initial src_clk = 1'b0;
  always #5 src_clk = ~src_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge src_clk);
    #1;
  endtask

  function automatic logic exp_mode();
    return (m_st == 0) ? BAUDRATE_MODE : DATA_MODE;
  endfunction

  function automatic logic [7:0] exp_msg();
    return (m_st == 0) ? {6'b0, sel_tab[m_baud]} : 8'(m_data);
  endfunction

  // Apply one cycle's worth of debounced presses to the model using the priority rules.
  task automatic model_press(input logic n, input logic i, input logic s);
    if (m_st == 3) return;
    if (s) begin
      if (m_st != 0 && !tx_busy) begin
        m_txd = m_data;
        m_st  = 3;
      end
    end else if (n) begin
      m_st = (m_st == 0) ? 1 : (m_st == 1) ? 2 : 0;
    end else if (i) begin
      if (m_st == 0)      m_baud = (m_baud + 1) % 3;
      else if (m_st == 1) m_data = (m_data / 16) * 16 + (m_data % 16 + 1) % 16;
      else                m_data = ((m_data / 16 + 1) % 16) * 16 + m_data % 16;
    end
  endtask

  task automatic press(input logic n, input logic i, input logic s);
    btn_next = n; btn_inc = i; btn_send = s;
    repeat (8) tick();
    model_press(n, i, s);
    btn_next = 1'b0; btn_inc = 1'b0; btn_send = 1'b0;
    repeat (10) tick();
  endtask

  task automatic model_reset();
    m_st = 0; m_baud = 0; m_data = 0; m_txd = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    model_reset();
    tick();
    checks++;
    if (mode !== BAUDRATE_MODE) begin failures++; $display("FAIL reset_mode: got %b expected %b", mode, BAUDRATE_MODE); end
    checks++;
    if (baud_sel !== SEL_9600) begin failures++; $display("FAIL reset_baud: got %h expected %h", baud_sel, SEL_9600); end
    checks++;
    if (msg !== {6'b0, SEL_9600}) begin failures++; $display("FAIL reset_msg: got %h expected %h", msg, {6'b0, SEL_9600}); end
    checks++;
    if (tx_data !== 8'h00 || tx_start !== 1'b0) begin
      failures++; $display("FAIL reset_tx: got data=%h start=%b expected data=00 start=0", tx_data, tx_start);
    end
  endtask

  task automatic test_baud_cycle();
    logic [1:0] prev;
    for (int k = 0; k < 3; k++) begin
      prev = sel_tab[m_baud];
      btn_inc = 1'b1;
      repeat (7) tick();
      checks++;
      if (baud_sel !== prev) begin failures++; $display("FAIL baud_early_%0d: got %h expected %h", k, baud_sel, prev); end
      tick();
      m_baud = (m_baud + 1) % 3;
      checks++;
      if (baud_sel !== sel_tab[m_baud]) begin failures++; $display("FAIL baud_edge7_%0d: got %h expected %h", k, baud_sel, sel_tab[m_baud]); end
      checks++;
      if (msg !== exp_msg()) begin failures++; $display("FAIL baud_msg_%0d: got %h expected %h", k, msg, exp_msg()); end
      btn_inc = 1'b0;
      repeat (10) tick();
    end
    checks++;
    if (baud_sel !== SEL_9600) begin failures++; $display("FAIL baud_wrap: got %h expected %h", baud_sel, SEL_9600); end
  endtask

  task automatic test_glitch();
    int len;
    len = $urandom_range(1, 3);
    btn_inc = 1'b1;
    repeat (len) tick();
    btn_inc = 1'b0;
    repeat (12) tick();
    checks++;
    if (baud_sel !== sel_tab[m_baud]) begin failures++; $display("FAIL glitch_%0d: got %h expected %h", len, baud_sel, sel_tab[m_baud]); end
    btn_inc = 1'b1; tick();
    btn_inc = 1'b0; tick();
    btn_inc = 1'b1; tick();
    btn_inc = 1'b0; tick();
    btn_inc = 1'b1;
    repeat (3) tick();
    checks++;
    if (baud_sel !== sel_tab[m_baud]) begin failures++; $display("FAIL bounce_early: got %h expected %h", baud_sel, sel_tab[m_baud]); end
    repeat (8) tick();
    m_baud = (m_baud + 1) % 3;
    btn_inc = 1'b0;
    repeat (10) tick();
    checks++;
    if (baud_sel !== sel_tab[m_baud]) begin failures++; $display("FAIL bounce_single: got %h expected %h", baud_sel, sel_tab[m_baud]); end
  endtask

  task automatic test_data_entry();
    press(1'b1, 1'b0, 1'b0);
    checks++;
    if (mode !== DATA_MODE || msg !== 8'h00) begin failures++; $display("FAIL enter_edit: got mode=%b msg=%h expected mode=1 msg=00", mode, msg); end
    repeat (17) press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    repeat (2) press(1'b0, 1'b1, 1'b0);
    checks++;
    if (msg !== 8'h21) begin failures++; $display("FAIL data_21: got %h expected 21", msg); end
    checks++;
    if (mode !== DATA_MODE) begin failures++; $display("FAIL data_mode: got %b expected %b", mode, DATA_MODE); end
    checks++;
    if (msg !== exp_msg()) begin failures++; $display("FAIL data_model: got %h expected %h", msg, exp_msg()); end
    // the bench must be back in the low-nibble field for the send scenarios
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_send();
    tx_busy = 1'b0;
    press(1'b0, 1'b0, 1'b1);
    checks++;
    if (tx_start !== 1'b1 || tx_data !== 8'h21) begin
      failures++; $display("FAIL send_start: got start=%b data=%h expected start=1 data=21", tx_start, tx_data);
    end
    repeat ($urandom_range(1, 20)) tick();
    press(1'b0, 1'b1, 1'b0);
    checks++;
    if (msg !== 8'h21 || tx_start !== 1'b1) begin
      failures++; $display("FAIL send_frozen: got msg=%h start=%b expected msg=21 start=1", msg, tx_start);
    end
    tx_busy = 1'b1;
    tick();
    tx_busy = 1'b0;
    checks++;
    if (tx_start !== 1'b0) begin failures++; $display("FAIL send_ack: got %b expected 0", tx_start); end
    repeat (2) tick();
    m_st = 1;
    press(1'b0, 1'b1, 1'b0);
    checks++;
    if (msg !== 8'h22 || mode !== DATA_MODE) begin failures++; $display("FAIL send_return: got msg=%h mode=%b expected msg=22 mode=1", msg, mode); end
  endtask

  task automatic test_send_busy();
    tx_busy = 1'b1;
    press(1'b0, 1'b0, 1'b1);
    checks++;
    if (tx_start !== 1'b0) begin failures++; $display("FAIL busy_send: got %b expected 0", tx_start); end
    press(1'b0, 1'b1, 1'b0);
    tx_busy = 1'b0;
    checks++;
    if (msg !== exp_msg()) begin failures++; $display("FAIL busy_still_edit: got %h expected %h", msg, exp_msg()); end
  endtask

  task automatic test_send_next_same();
    tx_busy = 1'b0;
    press(1'b1, 1'b0, 1'b1);
    checks++;
    if (tx_start !== 1'b1 || tx_data !== 8'(m_txd)) begin
      failures++; $display("FAIL same_send: got start=%b data=%h expected start=1 data=%h", tx_start, tx_data, 8'(m_txd));
    end
    tx_busy = 1'b1;
    tick();
    tx_busy = 1'b0;
    repeat (2) tick();
    m_st = 1;
    press(1'b0, 1'b1, 1'b0);
    checks++;
    if (msg !== exp_msg()) begin failures++; $display("FAIL same_next_lost: got %h expected %h", msg, exp_msg()); end
  endtask

  task automatic test_random_edit();
    int op;
    for (int k = 0; k < 24; k++) begin
      op = $urandom_range(0, 2);
      press(op == 0, op != 0, 1'b0);
      repeat ($urandom_range(0, 5)) tick();
      checks++;
      if (mode !== exp_mode() || msg !== exp_msg() || baud_sel !== sel_tab[m_baud]) begin
        failures++;
        $display("FAIL rand_%0d: got mode=%b msg=%h baud=%h expected mode=%b msg=%h baud=%h",
                 k, mode, msg, baud_sel, exp_mode(), exp_msg(), sel_tab[m_baud]);
      end
    end
  endtask

  task automatic test_reset_in_send();
    if (m_st == 0) press(1'b1, 1'b0, 1'b0);
    tx_busy = 1'b0;
    press(1'b0, 1'b0, 1'b1);
    checks++;
    if (tx_start !== 1'b1) begin failures++; $display("FAIL rst_send_pre: got %b expected 1", tx_start); end
    rst = 1'b1;
    tick();
    model_reset();
    checks++;
    if (tx_start !== 1'b0 || tx_data !== 8'h00 || mode !== BAUDRATE_MODE ||
        baud_sel !== SEL_9600 || msg !== {6'b0, SEL_9600}) begin
      failures++;
      $display("FAIL rst_send: got start=%b data=%h mode=%b baud=%h msg=%h expected 0 00 %b %h %h",
               tx_start, tx_data, mode, baud_sel, msg, BAUDRATE_MODE, SEL_9600, {6'b0, SEL_9600});
    end
    // a button held through reset release counts as a fresh press
    btn_next = 1'b1;
    tick();
    rst = 1'b0;
    repeat (10) tick();
    btn_next = 1'b0;
    m_st = 1;
    repeat (10) tick();
    checks++;
    if (mode !== DATA_MODE || msg !== 8'h00) begin failures++; $display("FAIL held_through_rst: got mode=%b msg=%h expected mode=1 msg=00", mode, msg); end
  endtask

  initial begin
    checks = 0; failures = 0;
    sel_tab[0] = SEL_9600; sel_tab[1] = SEL_57600; sel_tab[2] = SEL_115200;
    rst = 1'b1; btn_next = 1'b0; btn_inc = 1'b0; btn_send = 1'b0; tx_busy = 1'b0;
    model_reset();
    test_reset();
    test_baud_cycle();
    test_glitch();
    test_data_entry();
    test_send();
    test_send_busy();
    test_send_next_same();
    test_random_edit();
    test_reset_in_send();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
